// File: rtl/fir_64_mdc_periph_sequencer.sv
// Command-driven configuration master for the fir_64_mdc accelerator peripheral port.
// Executes queued write/read/wait-for-event commands one at a time, in order.
module fir_64_mdc_periph_sequencer #(
  parameter int ID         = 10,
  parameter int TX_ID      = 1,
  parameter int N_CORES    = 2,
  parameter int N_EVT      = 4,
  parameter int EVT_CORE   = 0,
  parameter int EVT_IDX    = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [1:0]               cmd_op_i,
  input  logic [31:0]              cmd_addr_i,
  input  logic [31:0]              cmd_data_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [31:0]              rsp_data_o,
  output logic                     busy_o,
  output logic                     err_o,
  input  logic [N_CORES*N_EVT-1:0] evt_i,
  output logic                     periph_req,
  input  logic                     periph_gnt,
  output logic [31:0]              periph_add,
  output logic                     periph_wen,
  output logic [3:0]               periph_be,
  output logic [31:0]              periph_data,
  output logic [ID-1:0]            periph_id,
  input  logic [31:0]              periph_r_data,
  input  logic                     periph_r_valid,
  input  logic [ID-1:0]            periph_r_id
);

  localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW      = AW + 1;
  localparam int TW      = $clog2(TIMEOUT + 1);
  localparam int EVT_BIT = EVT_CORE * N_EVT + EVT_IDX;

  localparam logic [ID-1:0] TX_ID_L  = ID'(TX_ID);
  localparam logic [CW-1:0] DEPTH_L  = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WAIT  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_WAIT_EVT,
    S_RSP_OUT
  } state_t;

  // Command FIFO storage and pointers
  logic [1:0]    r_fifo_op   [FIFO_DEPTH];
  logic [31:0]   r_fifo_addr [FIFO_DEPTH];
  logic [31:0]   r_fifo_data [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_head_op;
  logic [31:0]   w_head_addr;
  logic [31:0]   w_head_data;

  // FSM state and registered outputs
  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_periph_req;
  logic          w_periph_req_nxt;
  logic [31:0]   r_periph_add;
  logic [31:0]   w_periph_add_nxt;
  logic          r_periph_wen;
  logic          w_periph_wen_nxt;
  logic [31:0]   r_periph_data;
  logic [31:0]   w_periph_data_nxt;
  logic          r_rsp_valid;
  logic          w_rsp_valid_nxt;
  logic [31:0]   r_rsp_data;
  logic [31:0]   w_rsp_data_nxt;
  logic          r_err;
  logic          w_err_nxt;
  logic [TW-1:0] r_tmo;
  logic [TW-1:0] w_tmo_nxt;

  logic          r_evt_pend;
  logic          w_evt_clr;
  logic          w_evt;
  logic          w_unused_evt;

  assign w_full      = (r_count == DEPTH_L);
  assign w_empty     = (r_count == '0);
  assign w_push      = cmd_valid_i & ~w_full;
  assign w_head_op   = r_fifo_op[r_rd_ptr];
  assign w_head_addr = r_fifo_addr[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];

  assign w_evt        = evt_i[EVT_BIT];
  assign w_unused_evt = ^evt_i;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_op[r_wr_ptr]   <= cmd_op_i;
      r_fifo_addr[r_wr_ptr] <= cmd_addr_i;
      r_fifo_data[r_wr_ptr] <= cmd_data_i;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A new event outranks the clear so back-to-back events are never dropped
  always_ff @(posedge clk_i) begin
    if (rst_i) r_evt_pend <= 1'b0;
    else       r_evt_pend <= w_evt | (r_evt_pend & ~w_evt_clr);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_periph_req  <= 1'b0;
      r_periph_add  <= '0;
      r_periph_wen  <= 1'b0;
      r_periph_data <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_err         <= 1'b0;
      r_tmo         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_periph_req  <= w_periph_req_nxt;
      r_periph_add  <= w_periph_add_nxt;
      r_periph_wen  <= w_periph_wen_nxt;
      r_periph_data <= w_periph_data_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_data    <= w_rsp_data_nxt;
      r_err         <= w_err_nxt;
      r_tmo         <= w_tmo_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_periph_req_nxt  = r_periph_req;
    w_periph_add_nxt  = r_periph_add;
    w_periph_wen_nxt  = r_periph_wen;
    w_periph_data_nxt = r_periph_data;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_data_nxt    = r_rsp_data;
    w_err_nxt         = r_err;
    w_tmo_nxt         = r_tmo;
    w_pop             = 1'b0;
    w_evt_clr         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          case (w_head_op)
            OP_WRITE, OP_READ: begin
              w_state_nxt       = S_REQ;
              w_periph_req_nxt  = 1'b1;
              w_periph_add_nxt  = w_head_addr;
              w_periph_wen_nxt  = (w_head_op == OP_READ);
              w_periph_data_nxt = w_head_data;
            end
            OP_WAIT: w_state_nxt = S_WAIT_EVT;
            default: w_state_nxt = S_IDLE;
          endcase
        end
      end
      S_REQ: begin
        if (periph_gnt) begin
          w_periph_req_nxt = 1'b0;
          w_tmo_nxt        = '0;
          w_state_nxt      = S_RESP;
        end
      end
      S_RESP: begin
        if (periph_r_valid) begin
          if (periph_r_id != TX_ID_L) w_err_nxt = 1'b1;
          if (r_periph_wen) begin
            w_rsp_data_nxt  = periph_r_data;
            w_rsp_valid_nxt = 1'b1;
            w_state_nxt     = S_RSP_OUT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (r_tmo == TMO_LAST) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_tmo_nxt = r_tmo + TW'(1);
        end
      end
      S_WAIT_EVT: begin
        if (r_evt_pend) begin
          w_evt_clr   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_RSP_OUT: begin
        if (rsp_ready_i) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign cmd_ready_o = ~w_full;
  assign busy_o      = (r_state != S_IDLE) | ~w_empty;
  assign err_o       = r_err;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign periph_req  = r_periph_req;
  assign periph_add  = r_periph_add;
  assign periph_wen  = r_periph_wen;
  assign periph_data = r_periph_data;
  assign periph_be   = 4'hF;
  assign periph_id   = TX_ID_L;

endmodule
